ahb_lite_master: RTL and testbench
==================================

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving bus address/data width; legal values are 32 and 64.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port resetn, input, 1, reset (synchronous, active-low).
REQ-004 SHALL have port req_valid, input, 1, command offered.
REQ-005 SHALL have port req_ready, output, 1, command accepted on a cycle where req_valid && req_ready.
REQ-006 SHALL have ports req_write (in, 1), req_addr (in, XLEN), req_size (in, 3) and req_wdata (in, XLEN): command fields; req_wdata is full-lane (unshifted).
REQ-007 SHALL have ports rsp_valid (out, 1), rsp_rdata (out, XLEN) and rsp_err (out, 1): completion strobe, read data and error flag.
REQ-008 SHALL have AHB-Lite master outputs htrans (2), hwrite (1), haddr (XLEN), hsize (3), hburst (3), hprot (4), hmastlock (1) and hwdata (XLEN).
REQ-009 SHALL have AHB-Lite inputs hrdata (XLEN), hready (1) and hresp (1).

Function
REQ-010 SHALL issue only SINGLE NONSEQ transfers, with hburst=3'b000, hprot=4'b0011 and hmastlock=0 held constant.
REQ-011 SHALL drive req_ready = hready && (state==NORMAL).
REQ-012 SHALL, on an accepting edge, register htrans=NONSEQ and hwrite/haddr/hsize from the command; otherwise, on a hready=1 edge, SHALL register htrans=IDLE.
REQ-013 SHALL hold all address-phase outputs stable while hready=0.
REQ-014 SHALL treat an address phase as complete on a clk edge with hready=1 and htrans=NONSEQ; that transfer then enters the data phase.
REQ-015 SHALL register hwdata from the accepted command's req_wdata at the address-phase-completing edge and hold it through the whole data phase.
REQ-016 SHALL treat a data phase as complete on the first following edge with hready=1.
REQ-017 SHALL assert rsp_valid for exactly one cycle after each data-phase completion, with rsp_err=hresp and rsp_rdata=hrdata for reads (0 for writes), both sampled at that edge.
REQ-018 SHALL sustain one transfer per cycle with zero wait states: a new address phase overlaps the previous data phase.
REQ-019 SHALL deliver responses strictly in request order.
REQ-020 SHALL use error states NORMAL and ERR1, and SHALL move from NORMAL to ERR1 on an edge where hresp=1 && hready=0 while a data phase is active.
REQ-021 SHALL, on entering ERR1, set htrans=IDLE and cancel any pending NONSEQ address phase.
REQ-022 SHALL report a cancelled transfer as a response with rsp_valid=1 and rsp_err=1 in the cycle after the errored transfer's response.
REQ-023 SHALL move from ERR1 to NORMAL on the edge with hresp=1 && hready=1, which completes the errored transfer with rsp_err=1.
REQ-024 SHALL generate no response for an IDLE address phase.
REQ-025 SHALL treat req_size > log2(XLEN/8), or req_addr not aligned to the size, as illegal; this is checked by assertion only and the behaviour is undefined.
REQ-026 SHALL NOT issue a further command while hready=0, even if req_valid stays high; req_valid held high across wait states is legal.

Reset
REQ-027 SHALL, when resetn=0 at a clk edge, set htrans=IDLE, hwrite=0, haddr=0, hsize=0, hwdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, state=NORMAL and the data-phase valid flag=0.
REQ-028 SHALL silently abandon any in-flight transfer when reset is asserted mid-operation, producing no response.
REQ-029 SHALL hold req_ready=0 in the first cycle after reset release only if hready=0.

Structure
REQ-030 SHALL take from shared package ahb_lite_pkg: HTRANS_IDLE/NONSEQ, HSIZE_BYTE/HALF/WORD/DWORD, HBURST_SINGLE, HPROT_DEFAULT and the error-state enum.
REQ-031 SHALL be a single flat module with no sub-modules; ahb_lite_pkg is shared with the existing AHB memory model.

Verification
REQ-032 SHALL pass this scenario: write 0xDEADBEEF to 0x100 (size 2), then read 0x100, zero wait states -> htrans NONSEQ on consecutive cycles, hwdata=0xDEADBEEF in the cycle after the write's address phase, read rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-033 SHALL pass this scenario: 8 back-to-back reads with hready=1 throughout -> 8 rsp_valid pulses in 8 consecutive cycles, in order.
REQ-034 SHALL pass this scenario: hready=0 for 3 cycles during a data phase while the next request waits -> haddr/htrans held stable, req_ready=0, responses still in order.
REQ-035 SHALL pass this scenario: two-cycle ERROR on a read of 0x2000 with a read of 0x2004 pending -> htrans=IDLE, both responses have rsp_err=1, 0x2004 never completes on the bus.
REQ-036 SHALL pass this scenario: resetn=0 mid-data-phase -> all outputs at reset values next cycle and no rsp_valid.
REQ-037 SHALL pass this scenario: byte write 0xAB to 0x1000_0003 (XLEN=32) -> hsize=0, haddr=0x1000_0003, hwdata=req_wdata unshifted.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and helpers, used by the master and the AHB memory model.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic {
        StNormal,
        StErr1
    } err_state_e;

    // A command is legal when its size fits the bus and its address is size-aligned.
    function automatic logic cmd_legal(input logic [2:0] size, input logic [63:0] addr,
                                       input int unsigned xlen);
        logic [2:0]  max_size;
        logic [63:0] mask;
        max_size = (xlen == 64) ? HSIZE_DWORD : HSIZE_WORD;
        mask     = (64'd1 << size) - 64'd1;
        return (size <= max_size) && ((addr & mask) == 64'd0);
    endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite master issuing SINGLE NONSEQ transfers from a valid/ready command port,
// with pipelined address/data phases and two-cycle ERROR handling.
module ahb_lite_master
    import ahb_lite_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_size,
    input  logic [XLEN-1:0] req_wdata,

    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,

    output logic [1:0]      htrans,
    output logic            hwrite,
    output logic [XLEN-1:0] haddr,
    output logic [2:0]      hsize,
    output logic [2:0]      hburst,
    output logic [3:0]      hprot,
    output logic            hmastlock,
    output logic [XLEN-1:0] hwdata,

    input  logic [XLEN-1:0] hrdata,
    input  logic            hready,
    input  logic            hresp
);

    err_state_e      state_q;
    logic [1:0]      htrans_q;
    logic            hwrite_q;
    logic [XLEN-1:0] haddr_q;
    logic [2:0]      hsize_q;
    logic [XLEN-1:0] wdata_q;   // write data parked until the address phase completes
    logic [XLEN-1:0] hwdata_q;
    logic            dvalid_q;
    logic            dwrite_q;
    logic            cancel_q;  // an address phase was dropped by ERROR and still owes a response
    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic [XLEN-1:0] rsp_rdata_q;

    assign req_ready = hready && (state_q == StNormal);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StNormal;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            haddr_q     <= '0;
            hsize_q     <= HSIZE_BYTE;
            wdata_q     <= '0;
            hwdata_q    <= '0;
            dvalid_q    <= 1'b0;
            dwrite_q    <= 1'b0;
            cancel_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;

            // The dropped transfer reports only once the errored one has responded.
            if (cancel_q && (state_q == StNormal) && !dvalid_q) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                cancel_q    <= 1'b0;
            end

            if (dvalid_q && hready) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= hresp;
                rsp_rdata_q <= dwrite_q ? '0 : hrdata;
                dvalid_q    <= 1'b0;
            end

            if (hready && (htrans_q == HTRANS_NONSEQ)) begin
                dvalid_q <= 1'b1;
                dwrite_q <= hwrite_q;
                hwdata_q <= wdata_q;
            end

            unique case (state_q)
                StNormal: begin
                    if (dvalid_q && hresp && !hready) begin
                        state_q  <= StErr1;
                        htrans_q <= HTRANS_IDLE;
                        cancel_q <= (htrans_q == HTRANS_NONSEQ);
                    end else if (req_valid && hready) begin
                        htrans_q <= HTRANS_NONSEQ;
                        hwrite_q <= req_write;
                        haddr_q  <= req_addr;
                        hsize_q  <= req_size;
                        wdata_q  <= req_wdata;
                    end else if (hready) begin
                        htrans_q <= HTRANS_IDLE;
                    end
                end
                StErr1: begin
                    if (hready) begin
                        state_q <= StNormal;
                    end
                end
            endcase
        end
    end

    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign haddr     = haddr_q;
    assign hsize     = hsize_q;
    assign hwdata    = hwdata_q;
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_DEFAULT;
    assign hmastlock = 1'b0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    a_cmd_legal: assert property (@(posedge clk) disable iff (!resetn)
        (req_valid && req_ready) |-> cmd_legal(req_size, 64'(req_addr), XLEN));

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench: a bench-side AHB slave with memory, a queue model of expected responses
// and a per-cycle compare process.
module tb_ahb_lite_master;
    import ahb_lite_pkg::*;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] ERR_ADDR = 32'h0000_2000;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [XLEN-1:0] req_addr = '0;
    logic [2:0]      req_size = 3'd0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;
    logic [1:0]      htrans;
    logic            hwrite;
    logic [XLEN-1:0] haddr;
    logic [2:0]      hsize;
    logic [2:0]      hburst;
    logic [3:0]      hprot;
    logic            hmastlock;
    logic [XLEN-1:0] hwdata;
    logic [XLEN-1:0] hrdata = '0;
    logic            hready = 1'b1;
    logic            hresp = 1'b0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        origin;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [int unsigned];
    logic [31:0] slave_mem [int unsigned];
    int          rsp_cycles[$];
    logic [31:0] last_rdata = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ws = 0;
    int          bus_2004 = 0;
    bit          dp_act = 1'b0;
    bit          dp_wr = 1'b0;
    logic [31:0] dp_addr = '0;
    int          dp_cyc = 0;

    ahb_lite_master #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .haddr     (haddr),
        .hsize     (hsize),
        .hburst    (hburst),
        .hprot     (hprot),
        .hmastlock (hmastlock),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Slave: drives hready/hresp/hrdata at negedge, samples the bus just before posedge.
    initial begin : slave
        logic [1:0]  s_htrans;
        logic [31:0] s_haddr, s_hwdata;
        logic        s_hwrite, s_ready, s_resp, s_rst, n_ready, n_resp;
        logic [31:0] n_rdata;
        forever begin
            @(negedge clk);
            n_ready = 1'b1;
            n_resp  = 1'b0;
            n_rdata = '0;
            if (dp_act) begin
                if (dp_addr == ERR_ADDR) begin
                    n_resp  = 1'b1;
                    n_ready = (dp_cyc >= 1);
                end else begin
                    n_ready = (dp_cyc >= ws);
                    if (!dp_wr) n_rdata = slave_rd(dp_addr);
                end
            end
            hready = n_ready;
            hresp  = n_resp;
            hrdata = n_rdata;
            #4;
            s_htrans = htrans;
            s_haddr  = haddr;
            s_hwrite = hwrite;
            s_hwdata = hwdata;
            s_ready  = hready;
            s_resp   = hresp;
            s_rst    = resetn;
            @(posedge clk);
            if (!s_rst) begin
                dp_act = 1'b0;
                dp_cyc = 0;
            end else if (s_ready) begin
                if (dp_act && dp_wr && !s_resp) slave_mem[dp_addr] = s_hwdata;
                if (s_htrans == HTRANS_NONSEQ && s_haddr == 32'h0000_2004) bus_2004++;
                dp_act  = (s_htrans == HTRANS_NONSEQ);
                dp_addr = s_haddr;
                dp_wr   = s_hwrite;
                dp_cyc  = 0;
            end else begin
                dp_cyc++;
            end
        end
    end

    // Compare process: every response against the model, bus constants every cycle.
    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (resetn) begin
                check("hburst", 32'(hburst), 32'd0);
                check("hprot", 32'(hprot), 32'd3);
                check("hmastlock", 32'(hmastlock), 32'd0);
                if (rsp_valid) begin
                    rsp_cycles.push_back(cyc);
                    last_rdata = rsp_rdata;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got rsp_valid=1, required no response");
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] d);
        exp_t e;
        bit   acc;
        bit   cancel;
        acc       = 1'b0;
        cancel    = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_size  = sz;
        req_wdata = d;
        for (int i = 0; i < 64 && !acc; i++) begin
            #4;
            acc = req_ready;
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no acceptance of 0x%0h, required acceptance", a);
        end else begin
            foreach (exp_q[i]) if (exp_q[i].origin) cancel = 1'b1;
            if (cancel) begin
                e = '{rdata: 32'd0, err: 1'b1, origin: 1'b0};
            end else if (a == ERR_ADDR) begin
                e = '{rdata: 32'd0, err: 1'b1, origin: 1'b1};
            end else if (w) begin
                model_mem[a] = d;
                e = '{rdata: 32'd0, err: 1'b0, origin: 1'b0};
            end else begin
                e = '{rdata: model_rd(a), err: 1'b0, origin: 1'b0};
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_htrans"}, 32'(htrans), 32'd0);
        check({tag, "_hwrite"}, 32'(hwrite), 32'd0);
        check({tag, "_haddr"}, haddr, 32'd0);
        check({tag, "_hsize"}, 32'(hsize), 32'd0);
        check({tag, "_hwdata"}, hwdata, 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        resetn = 1'b1;
        @(negedge clk);
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Write 0xDEADBEEF to 0x100 then read it back, zero wait states.
        issue(1'b1, 32'h100, HSIZE_WORD, 32'hDEAD_BEEF);
        check("s1_wr_htrans", 32'(htrans), 32'(HTRANS_NONSEQ));
        check("s1_wr_haddr", haddr, 32'h100);
        check("s1_wr_hwrite", 32'(hwrite), 32'd1);
        check("s1_wr_hsize", 32'(hsize), 32'd2);
        issue(1'b0, 32'h100, HSIZE_WORD, 32'd0);
        check("s1_rd_htrans", 32'(htrans), 32'(HTRANS_NONSEQ));
        check("s1_rd_hwrite", 32'(hwrite), 32'd0);
        check("s1_hwdata", hwdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("s1_wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("s1_idle_after", 32'(htrans), 32'(HTRANS_IDLE));
        repeat (3) @(negedge clk);
        check("s1_read_data", last_rdata, 32'hDEAD_BEEF);
        check("s1_drained", 32'(exp_q.size()), 32'd0);

        // Eight back-to-back reads.
        rsp_cycles.delete();
        for (int i = 0; i < 8; i++) issue(1'b0, 32'h200 + 32'(4 * i), HSIZE_WORD, 32'd0);
        repeat (4) @(negedge clk);
        check("s2_rsp_count", 32'(rsp_cycles.size()), 32'd8);
        for (int i = 1; i < rsp_cycles.size(); i++)
            check("s2_consecutive", 32'(rsp_cycles[i] - rsp_cycles[i-1]), 32'd1);

        // Three wait states per data phase while a further request waits.
        rsp_cycles.delete();
        ws = 3;
        issue(1'b0, 32'h300, HSIZE_WORD, 32'd0);
        issue(1'b0, 32'h304, HSIZE_WORD, 32'd0);
        fork
            issue(1'b0, 32'h308, HSIZE_WORD, 32'd0);
            begin
                for (int i = 0; i < 3; i++) begin
                    #1;
                    check("s3_ready_low", 32'(req_ready), 32'd0);
                    check("s3_htrans_hold", 32'(htrans), 32'(HTRANS_NONSEQ));
                    check("s3_haddr_hold", haddr, 32'h304);
                    @(negedge clk);
                end
            end
        join
        repeat (20) @(negedge clk);
        ws = 0;
        check("s3_rsp_count", 32'(rsp_cycles.size()), 32'd3);
        check("s3_drained", 32'(exp_q.size()), 32'd0);

        // Two-cycle ERROR on 0x2000 with 0x2004 pending behind it.
        issue(1'b0, ERR_ADDR, HSIZE_WORD, 32'd0);
        issue(1'b0, 32'h2004, HSIZE_WORD, 32'd0);
        @(negedge clk);
        check("s4_htrans_idle", 32'(htrans), 32'(HTRANS_IDLE));
        #1;
        check("s4_ready_in_err1", 32'(req_ready), 32'd0);
        repeat (5) @(negedge clk);
        check("s4_no_bus_0x2004", 32'(bus_2004), 32'd0);
        check("s4_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a write data phase.
        ws = 3;
        issue(1'b1, 32'h404, HSIZE_WORD, 32'h1234_5678);
        issue(1'b0, 32'h400, HSIZE_WORD, 32'd0);
        check("s5_hwdata_live", hwdata, 32'h1234_5678);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_values("s5");
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        ws = 0;
        @(negedge clk);
        #1;
        check("s5_ready_after_release", 32'(req_ready), 32'd1);
        repeat (5) @(negedge clk);

        // Byte write to an unaligned-looking but byte-legal address, then read back.
        issue(1'b1, 32'h1000_0003, HSIZE_BYTE, 32'h0000_00AB);
        check("s6_hsize", 32'(hsize), 32'd0);
        check("s6_haddr", haddr, 32'h1000_0003);
        @(negedge clk);
        check("s6_hwdata", hwdata, 32'h0000_00AB);
        issue(1'b0, 32'h1000_0003, HSIZE_BYTE, 32'd0);
        repeat (4) @(negedge clk);
        check("s6_read_back", last_rdata, 32'h0000_00AB);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
